// File: rtl/alu_pkg.sv
// Shared types for the arbitrated ALU: function codes, FSM states and the default datapath width.
package alu_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;

    typedef enum logic [2:0] {
        F_OR  = 3'b000,
        F_AND = 3'b001,
        F_ADD = 3'b010,
        F_SUB = 3'b110,
        F_SLT = 3'b111
    } alu_f_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: OR/AND/ADD/SUB/SLT with a zero flag; unused codes yield 0.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       f,
    output logic [WIDTH-1:0] y,
    output logic             zero
);

    logic [WIDTH-1:0] diff;
    logic             ovf;
    logic             slt;

    always_comb begin
        diff = a + ~b + WIDTH'(1);
        // Signed less-than: sign of the difference, flipped when the subtraction overflowed
        ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        slt  = diff[WIDTH-1] ^ ovf;
        case (alu_f_t'(f))
            F_OR:    y = a | b;
            F_AND:   y = a & b;
            F_ADD:   y = a + b;
            F_SUB:   y = diff;
            F_SLT:   y = {{(WIDTH-1){1'b0}}, slt};
            default: y = '0;
        endcase
        zero = (y == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one ALU, with a single-entry result register
// and saturating per-requester grant counters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_f,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_f,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_y,
    output logic             res_zero,
    output logic             res_id,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1
);

    state_t           state;
    logic             prio;
    logic             free;
    logic             grant0;
    logic             grant1;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [2:0]       op_f;
    logic [WIDTH-1:0] alu_y;
    logic             alu_zero;

    // prio names the requester that wins when both are valid
    always_comb begin
        free   = (state == IDLE) || res_ready;
        grant0 = !reset && free && req0_valid && (!req1_valid || !prio);
        grant1 = !reset && free && req1_valid && (!req0_valid || prio);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign res_valid  = (state == HOLD);

    assign op_a = grant1 ? req1_a : req0_a;
    assign op_b = grant1 ? req1_b : req0_b;
    assign op_f = grant1 ? req1_f : req0_f;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a    (op_a),
        .b    (op_b),
        .f    (op_f),
        .y    (alu_y),
        .zero (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            res_y    <= '0;
            res_zero <= 1'b0;
            res_id   <= 1'b0;
            prio     <= 1'b0;
            cnt0     <= '0;
            cnt1     <= '0;
        end else if (grant0 || grant1) begin
            state    <= HOLD;
            res_y    <= alu_y;
            res_zero <= alu_zero;
            res_id   <= grant1;
            prio     <= grant0;
            if (grant0 && cnt0 != '1) cnt0 <= cnt0 + 16'd1;
            if (grant1 && cnt1 != '1) cnt1 <= cnt1 + 16'd1;
        end else if (state == HOLD && res_ready) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, corner-case sequences and a
// randomized run against a transaction-level reference model.
module tb_alu_arbiter;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]       req0_f, req1_f;
    logic             res_valid, res_ready;
    logic [WIDTH-1:0] res_y;
    logic             res_zero, res_id;
    logic [15:0]      cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_zero(res_zero), .res_id(res_id),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    // Reference model state: one outstanding result, who was granted last, grant totals
    bit          m_valid;
    logic [31:0] m_y;
    bit          m_zero;
    bit          m_id;
    int          m_last;
    int          m_cnt [2];
    bit          obs_r0, obs_r1;

    function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [2:0] f);
        case (f)
            3'd0:    return a | b;
            3'd1:    return a & b;
            3'd2:    return a + b;
            3'd6:    return a - b;
            3'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: check readies mid-cycle, advance the model at the edge, check registers after it
    task automatic cycle();
        int g;
        @(negedge clk);
        if (reset) g = -1;
        else if (m_valid && !res_ready) g = -1;
        else if (req0_valid && req1_valid) g = (m_last == 0) ? 1 : 0;
        else if (req0_valid) g = 0;
        else if (req1_valid) g = 1;
        else g = -1;
        obs_r0 = req0_ready;
        obs_r1 = req1_ready;
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, g == 0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, g == 1});
        @(posedge clk);
        if (reset) begin
            m_valid = 0; m_y = '0; m_zero = 0; m_id = 0; m_last = 1;
            m_cnt[0] = 0; m_cnt[1] = 0;
        end else if (g >= 0) begin
            m_valid = 1;
            m_y     = (g == 0) ? ref_alu(req0_a, req0_b, req0_f) : ref_alu(req1_a, req1_b, req1_f);
            m_zero  = (m_y == 0);
            m_id    = (g == 1);
            m_last  = g;
            if (m_cnt[g] < 65535) m_cnt[g] = m_cnt[g] + 1;
        end else if (m_valid && res_ready) begin
            m_valid = 0;
        end
        #1;
        chk("res_valid", {31'd0, res_valid}, {31'd0, m_valid});
        chk("res_y", res_y, m_y);
        chk("res_zero", {31'd0, res_zero}, {31'd0, m_zero});
        chk("res_id", {31'd0, res_id}, {31'd0, m_id});
        chk("cnt0", {16'd0, cnt0}, m_cnt[0]);
        chk("cnt1", {16'd0, cnt1}, m_cnt[1]);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        bit          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic [31:0] y;
        bit          zero;
    } vec_t;

    vec_t vt [12];

    initial begin
        vt[0]  = '{0, 32'd5,          32'd3,          3'b010, 32'd8,          0};
        vt[1]  = '{1, 32'd7,          32'd7,          3'b110, 32'd0,          1};
        vt[2]  = '{1, 32'hFFFF_FFFF,  32'd1,          3'b111, 32'd1,          0};
        vt[3]  = '{0, 32'h8000_0000,  32'h7FFF_FFFF,  3'b111, 32'd1,          0};
        vt[4]  = '{0, 32'h7FFF_FFFF,  32'h8000_0000,  3'b111, 32'd0,          1};
        vt[5]  = '{1, 32'hFFFF_FFFF,  32'd1,          3'b010, 32'd0,          1};
        vt[6]  = '{0, 32'd0,          32'd1,          3'b110, 32'hFFFF_FFFF,  0};
        vt[7]  = '{1, 32'hF0F0_0000,  32'h0F0F_00FF,  3'b000, 32'hFFFF_00FF,  0};
        vt[8]  = '{0, 32'hF0F0_1234,  32'h0FF0_FFFF,  3'b001, 32'h00F0_1234,  0};
        vt[9]  = '{1, 32'hDEAD_BEEF,  32'h1234_5678,  3'b011, 32'd0,          1};
        vt[10] = '{0, 32'hDEAD_BEEF,  32'h1234_5678,  3'b100, 32'd0,          1};
        vt[11] = '{1, 32'hDEAD_BEEF,  32'h1234_5678,  3'b101, 32'd0,          1};

        reset = 1; res_ready = 0;
        req0_valid = 1; req1_valid = 1;
        req0_a = '0; req0_b = '0; req0_f = '0;
        req1_a = '0; req1_b = '0; req1_f = '0;
        m_valid = 0; m_y = '0; m_zero = 0; m_id = 0; m_last = 1;
        m_cnt[0] = 0; m_cnt[1] = 0;

        // Reset with both requesting: readies must stay low, registers cleared
        cycle();
        cycle();
        chk("reset_res_valid", {31'd0, res_valid}, 32'd0);
        chk("reset_cnt0", {16'd0, cnt0}, 32'd0);
        reset = 0; req0_valid = 0; req1_valid = 0;
        cycle();

        // Directed vectors, one requester at a time, back-to-back
        res_ready = 1;
        for (int i = 0; i < 12; i++) begin
            req0_valid = !vt[i].id; req1_valid = vt[i].id;
            req0_a = vt[i].id ? $urandom : vt[i].a;
            req0_b = vt[i].id ? $urandom : vt[i].b;
            req0_f = vt[i].id ? 3'($urandom) : vt[i].f;
            req1_a = vt[i].id ? vt[i].a : $urandom;
            req1_b = vt[i].id ? vt[i].b : $urandom;
            req1_f = vt[i].id ? vt[i].f : 3'($urandom);
            cycle();
            chk($sformatf("vec%0d_y", i), res_y, vt[i].y);
            chk($sformatf("vec%0d_zero", i), {31'd0, res_zero}, {31'd0, vt[i].zero});
            chk($sformatf("vec%0d_id", i), {31'd0, res_id}, {31'd0, vt[i].id});
        end
        req0_valid = 0; req1_valid = 0;
        cycle();

        // Round-robin: both valid for 4 cycles right after reset
        reset = 1; cycle(); reset = 0;
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk($sformatf("rr%0d_grant1", i), {31'd0, obs_r1}, i % 2);
            chk($sformatf("rr%0d_id", i), {31'd0, res_id}, i % 2);
        end
        chk("rr_cnt0", {16'd0, cnt0}, 32'd2);
        chk("rr_cnt1", {16'd0, cnt1}, 32'd2);
        req0_valid = 0; req1_valid = 0;
        cycle();

        // Back-pressure: result held while res_ready low, then consume and accept together
        req0_valid = 1; req0_a = 32'd5; req0_b = 32'd3; req0_f = 3'b010;
        cycle();
        res_ready = 0; req0_a = 32'd1; req0_b = 32'd1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_ready0", {31'd0, obs_r0}, 32'd0);
            chk("stall_y", res_y, 32'd8);
        end
        res_ready = 1;
        cycle();
        chk("release_ready0", {31'd0, obs_r0}, 32'd1);
        chk("release_y", res_y, 32'd2);

        // Reset in HOLD after a grant to 0: result dropped, pointer back to requester 0
        req0_valid = 1; req1_valid = 1; reset = 1; res_ready = 0;
        cycle();
        chk("rst_hold_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_hold_cnt0", {16'd0, cnt0}, 32'd0);
        chk("rst_hold_cnt1", {16'd0, cnt1}, 32'd0);
        reset = 0;
        cycle();
        chk("rst_first_grant0", {31'd0, obs_r0}, 32'd1);
        res_ready = 1;
        req0_valid = 0; req1_valid = 0;
        cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 49) == 0);
            req0_valid = $urandom_range(0, 1);
            req1_valid = $urandom_range(0, 1);
            res_ready  = ($urandom_range(0, 3) != 0);
            req0_a = rnd_operand(); req0_b = rnd_operand(); req0_f = 3'($urandom);
            req1_a = rnd_operand(); req1_b = rnd_operand(); req1_f = 3'($urandom);
            cycle();
        end

        // Counter saturation: 65535 grants to requester 0, then one more
        reset = 1; req0_valid = 0; req1_valid = 0;
        cycle();
        reset = 0; res_ready = 1; req0_valid = 1;
        req0_a = 32'd1; req0_b = 32'd2; req0_f = 3'b010;
        for (int i = 0; i < 65535; i++) cycle();
        chk("sat_reach", {16'd0, cnt0}, 32'hFFFF);
        cycle();
        chk("sat_hold", {16'd0, cnt0}, 32'hFFFF);
        chk("sat_cnt1", {16'd0, cnt1}, 32'd0);
        req0_valid = 0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester n presents an operation.
REQ-005 SHALL have ports req0_ready and req1_ready, output, 1 bit each: requester n's operation is accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a and req1_b, input, WIDTH bits each: operands A and B.
REQ-007 SHALL have ports req0_f and req1_f, input, 3 bits each: ALU function code.
REQ-008 SHALL have port res_valid, output, 1 bit: the result register holds an unconsumed result.
REQ-009 SHALL have port res_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-010 SHALL have port res_y, output, WIDTH bits: the result value.
REQ-011 SHALL have port res_zero, output, 1 bit: high when res_y is zero.
REQ-012 SHALL have port res_id, output, 1 bit: the index of the requester that owns the result.
REQ-013 SHALL have ports cnt0 and cnt1, output, 16 bits each: saturating count of operations accepted per requester.

Function
REQ-014 SHALL decode function codes as follows: 000 OR; 001 AND; 010 ADD; 110 SUB (A + ~B + 1); 111 SLT (result 1 when signed A < signed B, else 0); 011, 100 and 101 give result 0.
REQ-015 SHALL implement the FSM states IDLE (result register empty) and HOLD (result valid).
REQ-016 SHALL make the result register free when state is IDLE, or when state is HOLD and res_ready is high.
REQ-017 SHALL complete a handshake on requester n when reqn_valid and reqn_ready are both high.
REQ-018 SHALL make a granted handshake in cycle N produce res_valid high in cycle N+1, with res_y, res_zero and res_id registered.
REQ-019 SHALL assert at most one reqn_ready per cycle, and only when the result register is free.
REQ-020 SHALL make reqn_ready depend combinationally on the valids, res_ready and state only, never on operands.
REQ-021 SHALL grant the only requester that is valid when exactly one is valid.
REQ-022 SHALL arbitrate by round-robin when both are valid: the requester not granted last wins; priority pointer resets to requester 0.
REQ-023 SHALL update the priority pointer only on a completed grant.
REQ-024 SHALL, in HOLD, hold res_y, res_zero and res_id stable until res_ready is high.
REQ-025 SHALL, in HOLD with res_ready high and a valid request, consume and accept in the same cycle (back-to-back, one result per cycle); without a valid request, go to IDLE.
REQ-026 SHALL treat res_ready as don't-care when res_valid is low.
REQ-027 SHALL compute ADD/SUB modulo 2^WIDTH, discarding carry and overflow.
REQ-028 SHALL compute SLT from the sign of the difference corrected by overflow, so that 0x80000000 < 0x7FFFFFFF gives 1.
REQ-029 SHALL increment cntn by 1 on each grant to requester n and saturate at 0xFFFF.

Reset
REQ-030 SHALL, while reset is high at a clock edge, set state IDLE, res_valid 0, res_y 0, res_zero 0, res_id 0, priority pointer to requester 0 and cnt0/cnt1 to 0.
REQ-031 SHALL hold req0_ready and req1_ready low during any cycle in which reset is high.
REQ-032 SHALL discard, when reset is asserted in HOLD, the held result without a handshake.

Structure
REQ-033 SHALL place the alu_f_t 3-bit function-code enum and the WIDTH default in the shared package alu_pkg.
REQ-034 SHALL instantiate the combinational sub-module alu (inputs A, B, F; outputs Y, zero) for the arithmetic, with the FSM, arbitration and counters in alu_arbiter.

Verification
REQ-035 SHALL verify: req0 only, A=5, B=3, F=010 -> next cycle res_valid=1, res_y=8, res_zero=0, res_id=0, cnt0=1.
REQ-036 SHALL verify: req1 only, A=7, B=7, F=110 -> res_y=0, res_zero=1, res_id=1; then A=0xFFFFFFFF, B=1, F=111 -> res_y=1.
REQ-037 SHALL verify: both valid continuously for 4 cycles with res_ready=1 -> grants alternate 0,1,0,1, res_id follows one cycle later, and cnt0=cnt1=2.
REQ-038 SHALL verify: res_ready=0 for 3 cycles with req0 valid -> res_y stable, req0_ready=0; when res_ready=1 -> req0 accepted in that same cycle.
REQ-039 SHALL verify: reset asserted in HOLD -> next cycle res_valid=0, counters 0; first both-valid grant goes to requester 0.
REQ-040 SHALL verify: force cnt0 to 0xFFFF, one more grant to requester 0 -> cnt0 stays 0xFFFF.
